signextend_arbiter: RTL and testbench

- Shares one `signextend` instance between NUM_REQ requesters using round-robin arbitration.
- Drives the unit's `en_n`/`dataIn` and tracks which requester owns each in-flight word.
- A DELAY-deep tag pipeline, stepped in lockstep with the unit, returns each result on one response channel tagged with the requester ID.
- Sits between the lane front-ends and the shared sign-extension datapath.

---
 rtl/signextend_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/signextend.sv | 39 +++
 rtl/signextend_arbiter.sv | 111 +++++++++++
 tb/tb_signextend_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/signextend_pkg.sv
// Shared constants and types for the sign-extension arbiter slice:
// element widths, the in-flight tag record and the occupancy state.
package signextend_pkg;

    localparam int SE_NUM_REQ = 4;
    localparam int SE_DW_IN   = 4;
    localparam int SE_DEPTH   = 2;
    localparam int SE_DW_OUT  = 8;
    localparam int SE_ID_W    = $clog2(SE_NUM_REQ);
    localparam int SE_W_IN    = SE_DW_IN * SE_DEPTH;
    localparam int SE_W_OUT   = SE_DW_OUT * SE_DEPTH;

    typedef struct packed {
        logic               valid;
        logic [SE_ID_W-1:0] id;
    } tag_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above the
// pointer, wrapping modulo NUM_REQ (NUM_REQ must be a power of two).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    off;

    // rot[k] is the request k positions above the pointer; the ID_W-bit
    // addition wraps for free because NUM_REQ is a power of two.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [ID_W-1:0] src;
        assign src     = ptr_i + ID_W'(gi);
        assign rot[gi] = req_i[src];
    end

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
            end
        end
    end

    assign any_o   = |req_i;
    assign idx_o   = ptr_i + off;
    assign grant_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/signextend.sv
// Shared sign-extension datapath: widens every element of a word and
// delivers it after DELAY enabled cycles; en_n=1 freezes the pipeline.
module signextend #(
    parameter int DATA_WIDTH_IN  = 4,
    parameter int DEPTH          = 2,
    parameter int DATA_WIDTH_OUT = 8,
    parameter int DELAY          = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_n,
    input  logic [DATA_WIDTH_IN*DEPTH-1:0]  dataIn,
    output logic [DATA_WIDTH_OUT*DEPTH-1:0] dataOut
);

    localparam int W_OUT = DATA_WIDTH_OUT * DEPTH;

    logic [W_OUT-1:0] ext;
    logic [W_OUT-1:0] stage_q [DELAY];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elem
        assign ext[gi*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] =
            {{(DATA_WIDTH_OUT - DATA_WIDTH_IN){dataIn[gi*DATA_WIDTH_IN + DATA_WIDTH_IN - 1]}},
             dataIn[gi*DATA_WIDTH_IN +: DATA_WIDTH_IN]};
    end

    for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stage_q[gi] <= '0;
            end else if (!en_n) begin
                stage_q[gi] <= (gi == 0) ? ext : stage_q[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    assign dataOut = stage_q[DELAY-1];

endmodule

// File: rtl/signextend_arbiter.sv
// Shares one signextend unit between NUM_REQ requesters: round-robin issue,
// a DELAY-deep tag pipeline in lockstep with the unit, one tagged response.
module signextend_arbiter
    import signextend_pkg::*;
#(
    parameter int NUM_REQ        = SE_NUM_REQ,
    parameter int DATA_WIDTH_IN  = SE_DW_IN,
    parameter int DEPTH          = SE_DEPTH,
    parameter int DATA_WIDTH_OUT = SE_DW_OUT,
    parameter int DELAY          = 1,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ*DATA_WIDTH_IN*DEPTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic                                    se_en_n,
    output logic [DATA_WIDTH_IN*DEPTH-1:0]          se_dataIn,
    input  logic [DATA_WIDTH_OUT*DEPTH-1:0]         se_dataOut,
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [ID_W-1:0]                         rsp_id,
    output logic [DATA_WIDTH_OUT*DEPTH-1:0]         rsp_data,
    output logic                                    busy
);

    localparam int W_IN  = DATA_WIDTH_IN * DEPTH;
    localparam int OCC_W = $clog2(DELAY + 1);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gidx;
    logic               gany;
    logic               adv;
    logic               accept;
    logic               hs;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [W_IN-1:0]    din_q;
    logic [OCC_W-1:0]   occ_q, occ_d;
    state_e             state_q, state_d;
    tag_t               tag_d;
    tag_t               tag_q [DELAY];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (gidx),
        .any_o   (gany)
    );

    // A presented but unaccepted response freezes everything upstream.
    assign adv    = !(rsp_valid && !rsp_ready);
    assign accept = gany && adv && rst;
    assign hs     = rsp_valid && rsp_ready;

    assign req_ready = accept ? grant : '0;
    assign se_en_n   = !(adv && rst);
    assign se_dataIn = accept ? req_data[gidx*W_IN +: W_IN] : din_q;

    assign rsp_valid = tag_q[DELAY-1].valid;
    assign rsp_id    = tag_q[DELAY-1].id;
    assign rsp_data  = se_dataOut;
    assign busy      = (state_q != IDLE);

    always_comb begin
        tag_d.valid = accept;
        tag_d.id    = accept ? gidx : '0;
        ptr_d       = accept ? gidx + ID_W'(1) : ptr_q;
        occ_d       = occ_q + OCC_W'(accept) - OCC_W'(hs);
        if (occ_d == '0) begin
            state_d = IDLE;
        end else if (!adv) begin
            state_d = HOLD;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            din_q   <= '0;
            occ_q   <= '0;
            state_q <= IDLE;
        end else begin
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
            state_q <= state_d;
            if (accept) begin
                din_q <= se_dataIn;
            end
        end
    end

    // Tag stages shift only with the shared unit so IDs stay aligned with data.
    for (genvar gi = 0; gi < DELAY; gi++) begin : g_tag
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tag_q[gi] <= '0;
            end else if (adv) begin
                tag_q[gi] <= (gi == 0) ? tag_d : tag_q[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

endmodule

// File: tb/tb_signextend_arbiter.sv
// Directed bench for signextend_arbiter: a DELAY=1 and a DELAY=3 instance,
// each checked every cycle against a queue-based response model.
module tb_signextend_arbiter;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          age;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_s       [2];
    logic [3:0]  req_valid_s [2];
    logic [31:0] req_data_s  [2];
    logic        rsp_ready_s [2];
    logic [3:0]  req_ready_s [2];
    logic        se_en_n_s   [2];
    logic [7:0]  se_din_s    [2];
    logic [15:0] se_dout_s   [2];
    logic        rsp_valid_s [2];
    logic [1:0]  rsp_id_s    [2];
    logic [15:0] rsp_data_s  [2];
    logic        busy_s      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Element-wise two's-complement widening of 4-bit nibbles to bytes.
    function automatic logic [15:0] sext8(input logic [7:0] w);
        int lo, hi;
        lo = int'(w[3:0]);
        hi = int'(w[7:4]);
        if (lo >= 8) lo = lo + 240;
        if (hi >= 8) hi = hi + 240;
        return 16'(hi * 256 + lo);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int D = (gi == 0) ? 1 : 3;

        signextend_arbiter #(.DELAY(D)) u_dut (
            .clk        (clk),
            .rst        (rst_s[gi]),
            .req_valid  (req_valid_s[gi]),
            .req_data   (req_data_s[gi]),
            .req_ready  (req_ready_s[gi]),
            .se_en_n    (se_en_n_s[gi]),
            .se_dataIn  (se_din_s[gi]),
            .se_dataOut (se_dout_s[gi]),
            .rsp_valid  (rsp_valid_s[gi]),
            .rsp_ready  (rsp_ready_s[gi]),
            .rsp_id     (rsp_id_s[gi]),
            .rsp_data   (rsp_data_s[gi]),
            .busy       (busy_s[gi])
        );

        signextend #(.DELAY(D)) u_se (
            .clk     (clk),
            .rst     (rst_s[gi]),
            .en_n    (se_en_n_s[gi]),
            .dataIn  (se_din_s[gi]),
            .dataOut (se_dout_s[gi])
        );

        ent_t        q[$];
        ent_t        e;
        int          ptr = 0;
        int          g;
        logic [7:0]  last_din = 8'h00;
        logic [7:0]  din;
        logic [3:0]  er;
        bit          rv, adv, found;

        always @(negedge clk) begin
            if (!rst_s[gi]) begin
                q.delete();
                ptr      = 0;
                last_din = 8'h00;
                chk("rst_req_ready", 32'(req_ready_s[gi]), 32'h0);
                chk("rst_rsp_valid", 32'(rsp_valid_s[gi]), 32'h0);
                chk("rst_rsp_id",    32'(rsp_id_s[gi]),    32'h0);
                chk("rst_busy",      32'(busy_s[gi]),      32'h0);
                chk("rst_se_en_n",   32'(se_en_n_s[gi]),   32'h1);
                chk("rst_se_dataIn", 32'(se_din_s[gi]),    32'h0);
            end else begin
                rv    = (q.size() > 0) && (q[0].age == D);
                adv   = !(rv && !rsp_ready_s[gi]);
                found = 1'b0;
                g     = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && req_valid_s[gi][(ptr + k) % 4]) begin
                        found = 1'b1;
                        g     = (ptr + k) % 4;
                    end
                end
                din = req_data_s[gi][g*8 +: 8];
                er  = (found && adv) ? 4'(1 << g) : 4'b0000;
                chk("m_req_ready", 32'(req_ready_s[gi]), 32'(er));
                chk("m_rsp_valid", 32'(rsp_valid_s[gi]), 32'(rv));
                chk("m_busy",      32'(busy_s[gi]),      32'(q.size() != 0));
                chk("m_se_en_n",   32'(se_en_n_s[gi]),   32'(!adv));
                chk("m_se_dataIn", 32'(se_din_s[gi]),    32'((found && adv) ? din : last_din));
                if (rv) begin
                    chk("m_rsp_id",   32'(rsp_id_s[gi]),   32'(q[0].id));
                    chk("m_rsp_data", 32'(rsp_data_s[gi]), 32'(q[0].data));
                end
                if (rv && rsp_ready_s[gi]) begin
                    $display("inst%0d rsp id=%0d data=%h", gi, q[0].id, q[0].data);
                    void'(q.pop_front());
                end
                if (adv) begin
                    for (int j = 0; j < q.size(); j++) q[j].age = q[j].age + 1;
                    if (found) begin
                        e.id   = g;
                        e.data = sext8(din);
                        e.age  = 1;
                        q.push_back(e);
                        ptr      = (g + 1) % 4;
                        last_din = din;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input int n);
        rst_s[n] = 1'b0;
        tick();
        rst_s[n] = 1'b1;
    endtask

    logic [15:0] rr_exp [4];

    initial begin
        rr_exp = '{16'h07ff, 16'hf800, 16'h01f8, 16'hff01};
        for (int n = 0; n < 2; n++) begin
            rst_s[n]       = 1'b1;
            req_valid_s[n] = 4'b0000;
            req_data_s[n]  = 32'h0;
            rsp_ready_s[n] = 1'b1;
        end
        #1;
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        #1;
        chk("async_rst_busy",    32'(busy_s[0]),    32'h0);
        chk("async_rst_se_en_n", 32'(se_en_n_s[1]), 32'h1);
        tick();
        tick();
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;

        // Single request from requester 0.
        req_valid_s[0] = 4'b0001;
        req_data_s[0]  = 32'h0000_00a5;
        @(negedge clk);
        chk("single_ready",  32'(req_ready_s[0]), 32'h1);
        chk("single_dataIn", 32'(se_din_s[0]),    32'ha5);
        tick();
        req_valid_s[0] = 4'b0000;
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid_s[0]), 32'h1);
        chk("single_rsp_id",    32'(rsp_id_s[0]),    32'h0);
        chk("single_rsp_data",  32'(rsp_data_s[0]),  32'hfa05);
        tick();

        // Round-robin fairness with all four requesters valid.
        pulse_reset(0);
        req_data_s[0]  = 32'hf118_807f;
        req_valid_s[0] = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rr_grant", 32'(req_ready_s[0]), 32'(1 << (c % 4)));
            if (c > 0) begin
                chk("rr_rsp_id",   32'(rsp_id_s[0]),   32'((c - 1) % 4));
                chk("rr_rsp_data", 32'(rsp_data_s[0]), 32'(rr_exp[(c - 1) % 4]));
            end
            tick();
        end
        req_valid_s[0] = 4'b0000;
        @(negedge clk);
        chk("rr_last_id",   32'(rsp_id_s[0]),   32'h3);
        chk("rr_last_data", 32'(rsp_data_s[0]), 32'hff01);
        tick();

        // Pointer at 3, requesters 0 and 2: wrap to 0, then skip to 2.
        pulse_reset(0);
        req_data_s[0]  = 32'h005a_00c3;
        req_valid_s[0] = 4'b0100;
        @(negedge clk);
        chk("wrap_first", 32'(req_ready_s[0]), 32'h4);
        tick();
        req_valid_s[0] = 4'b0101;
        @(negedge clk);
        chk("wrap_grant0", 32'(req_ready_s[0]), 32'h1);
        tick();
        @(negedge clk);
        chk("skip_grant2",  32'(req_ready_s[0]), 32'h4);
        chk("wrap_rsp_id",  32'(rsp_id_s[0]),    32'h0);
        chk("wrap_rsp_dat", 32'(rsp_data_s[0]),  32'hfc03);
        tick();
        req_valid_s[0] = 4'b0000;
        @(negedge clk);
        chk("skip_rsp_id",  32'(rsp_id_s[0]),   32'h2);
        chk("skip_rsp_dat", 32'(rsp_data_s[0]), 32'h05fa);
        tick();

        // Reset with one word in flight.
        req_data_s[0]  = 32'h0000_9600;
        req_valid_s[0] = 4'b0010;
        @(negedge clk);
        chk("mid_accept", 32'(req_ready_s[0]), 32'h2);
        tick();
        chk("mid_busy_before", 32'(busy_s[0]), 32'h1);
        rst_s[0]       = 1'b0;
        req_valid_s[0] = 4'b1000;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid_s[0]), 32'h0);
        chk("mid_rst_busy",      32'(busy_s[0]),      32'h0);
        chk("mid_rst_ready",     32'(req_ready_s[0]), 32'h0);
        chk("mid_rst_en_n",      32'(se_en_n_s[0]),   32'h1);
        chk("mid_rst_dataIn",    32'(se_din_s[0]),    32'h0);
        tick();
        rst_s[0]       = 1'b1;
        req_valid_s[0] = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid_s[0]), 32'h0);
            tick();
        end

        // DELAY=3: burst of three from requester 1.
        req_data_s[1]  = 32'h0000_3c00;
        req_valid_s[1] = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("d3_ready",     32'(req_ready_s[1]), (c < 3) ? 32'h2 : 32'h0);
            chk("d3_rsp_valid", 32'(rsp_valid_s[1]), 32'(c >= 3));
            if (c >= 3) begin
                chk("d3_rsp_id",   32'(rsp_id_s[1]),   32'h1);
                chk("d3_rsp_data", 32'(rsp_data_s[1]), 32'h03fc);
            end
            tick();
            if (c == 2) req_valid_s[1] = 4'b0000;
        end
        @(negedge clk);
        chk("d3_drained", 32'(busy_s[1]), 32'h0);
        tick();

        // DELAY=3 backpressure: two words in flight, response held 3 cycles.
        req_data_s[1]  = 32'h007e_0081;
        req_valid_s[1] = 4'b0101;
        rsp_ready_s[1] = 1'b0;
        @(negedge clk);
        chk("bp_grant2", 32'(req_ready_s[1]), 32'h4);
        tick();
        @(negedge clk);
        chk("bp_grant0", 32'(req_ready_s[1]), 32'h1);
        tick();
        req_valid_s[1] = 4'b0000;
        @(negedge clk);
        chk("bp_not_yet", 32'(rsp_valid_s[1]), 32'h0);
        tick();
        req_valid_s[1] = 4'b1000;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_en_n",  32'(se_en_n_s[1]),   32'h1);
            chk("bp_ready", 32'(req_ready_s[1]), 32'h0);
            chk("bp_id",    32'(rsp_id_s[1]),    32'h2);
            chk("bp_data",  32'(rsp_data_s[1]),  32'h07fe);
            chk("bp_busy",  32'(busy_s[1]),      32'h1);
            tick();
        end
        rsp_ready_s[1] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(req_ready_s[1]), 32'h8);
        chk("bp_release_id",    32'(rsp_id_s[1]),    32'h2);
        tick();
        req_valid_s[1] = 4'b0000;
        @(negedge clk);
        chk("bp_second_valid", 32'(rsp_valid_s[1]), 32'h1);
        chk("bp_second_id",    32'(rsp_id_s[1]),    32'h0);
        chk("bp_second_data",  32'(rsp_data_s[1]),  32'hf801);
        tick();
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        chk("final_idle0", 32'(busy_s[0]), 32'h0);
        chk("final_idle1", 32'(busy_s[1]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
